// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with boot, stall hold,
// jump/return redirect, a pending-interrupt latch, a one-cycle interrupt
// entry state with return-PC capture, and interrupt masking until RTI.
//
// Redirect strobes have no handshake. JumpEn and RetEn are
// single-cycle requests with no ready. They are honoured only in RUN,
// where JumpEn beats RetEn and both beat interrupt entry. A redirect
// during BOOT or INT_ENTRY is dropped, so the producer must hold or
// replay it.
module pc_sequencer #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32),
  parameter logic [ADDR_W-1:0] INT_VEC   = ADDR_W'(0),
  parameter int unsigned       INC       = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Stall,
  input  logic              JumpEn,
  input  logic [ADDR_W-1:0] JumpAddr,
  input  logic              RetEn,
  input  logic              IsRti,
  input  logic [ADDR_W-1:0] RetAddr,
  input  logic              IntReq,
  output logic [ADDR_W-1:0] OutPc,
  output logic              PcValid,
  output logic              IntAck,
  output logic [ADDR_W-1:0] SavedPc,
  output logic              InIsr,
  output logic [1:0]        DbgState
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_ENTRY = 2'd2;

  localparam logic [ADDR_W-1:0] INC_W = ADDR_W'(INC);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              ack_q, ack_d;
  logic [ADDR_W-1:0] saved_q, saved_d;
  logic              isr_q, isr_d;
  logic              pend_q, pend_d;
  logic              int_elig;

  // An interrupt is enterable when requested now or earlier, unmasked and
  // fetch is not being held.
  assign int_elig = (pend_q | IntReq) & ~isr_q & ~Stall;

  // Next-state logic: FSM plus PC source selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    saved_d = saved_q;
    isr_d   = isr_q;
    pend_d  = pend_q;
    case (state_q)
      ST_BOOT: begin
        // First fetch of RESET_VEC becomes valid. Redirects and stall are ignored.
        state_d = ST_RUN;
        valid_d = 1'b1;
        pend_d  = IntReq;
      end
      ST_ENTRY: begin
        // Handler starts fetching at INT_VEC. New requests wait until RTI.
        state_d = ST_RUN;
        valid_d = 1'b1;
        isr_d   = 1'b1;
        pend_d  = pend_q | IntReq;
      end
      ST_RUN: begin
        // Any request not taken this cycle is remembered.
        pend_d = pend_q | IntReq;
        if (JumpEn) begin
          pc_d = JumpAddr;
        end else if (RetEn) begin
          pc_d = RetAddr;
          if (IsRti) begin
            isr_d = 1'b0;
          end
        end else if (int_elig) begin
          // A preceding redirect has already landed in pc_q, so the
          // captured return point is the redirect target.
          saved_d = pc_q;
          pc_d    = INT_VEC;
          valid_d = 1'b0;
          pend_d  = 1'b0;
          state_d = ST_ENTRY;
        end else if (!Stall) begin
          pc_d = pc_q + INC_W;  // wraps modulo 2^ADDR_W
        end
      end
      default: begin
        // Unused encoding: restart through BOOT.
        state_d = ST_BOOT;
      end
    endcase
  end

  // IntAck is a registered decode of the entry state, so it can never stay high for two cycles.
  assign ack_d = (state_d == ST_ENTRY);

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      saved_q <= '0;
      isr_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      saved_q <= saved_d;
      isr_q   <= isr_d;
      pend_q  <= pend_d;
    end
  end

  assign OutPc    = pc_q;
  assign PcValid  = valid_q;
  assign IntAck   = ack_q;
  assign SavedPc  = saved_q;
  assign InIsr    = isr_q;
  assign DbgState = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: three instances (32-bit INC=1, 8-bit INC=1,
// 8-bit INC=4) share the control inputs. A behavioural model predicts the
// outputs of every instance, and literal checks fix key points of the
// directed sequence.
module tb_pc_sequencer;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Rst = 1'b1;
  logic        Stall = 1'b0, JumpEn = 1'b0, RetEn = 1'b0, IsRti = 1'b0, IntReq = 1'b0;
  logic [31:0] jaddr0 = '0;
  logic [7:0]  jaddr1 = '0, jaddr2 = '0;
  logic [31:0] raddr = '0;

  logic [31:0] pc0, saved0;
  logic [7:0]  pc1, saved1, pc2, saved2;
  logic [2:0]  valid, ack, isr;
  logic [1:0]  dbg0, dbg1, dbg2;

  pc_sequencer #(.ADDR_W(32), .RESET_VEC(32'd32), .INT_VEC(32'd0), .INC(1)) u0 (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .JumpEn(JumpEn), .JumpAddr(jaddr0),
    .RetEn(RetEn), .IsRti(IsRti), .RetAddr(raddr), .IntReq(IntReq),
    .OutPc(pc0), .PcValid(valid[0]), .IntAck(ack[0]), .SavedPc(saved0),
    .InIsr(isr[0]), .DbgState(dbg0));

  pc_sequencer #(.ADDR_W(8), .RESET_VEC(8'd32), .INT_VEC(8'd0), .INC(1)) u1 (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .JumpEn(JumpEn), .JumpAddr(jaddr1),
    .RetEn(RetEn), .IsRti(IsRti), .RetAddr(raddr[7:0]), .IntReq(IntReq),
    .OutPc(pc1), .PcValid(valid[1]), .IntAck(ack[1]), .SavedPc(saved1),
    .InIsr(isr[1]), .DbgState(dbg1));

  pc_sequencer #(.ADDR_W(8), .RESET_VEC(8'd32), .INT_VEC(8'd0), .INC(4)) u2 (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .JumpEn(JumpEn), .JumpAddr(jaddr2),
    .RetEn(RetEn), .IsRti(IsRti), .RetAddr(raddr[7:0]), .IntReq(IntReq),
    .OutPc(pc2), .PcValid(valid[2]), .IntAck(ack[2]), .SavedPc(saved2),
    .InIsr(isr[2]), .DbgState(dbg2));

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        booting;   // first cycle after reset
    logic        entering;  // interrupt entry cycle
    logic [31:0] pc;
    logic        valid;
    logic        ack;
    logic [31:0] saved;
    logic        isr;
    logic        pend;
  } mdl_t;

  mdl_t        m[3];
  logic [31:0] mask[3];
  logic [31:0] incr[3];
  logic [31:0] jt[3];

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  function automatic mdl_t step(mdl_t c, int i);
    mdl_t n;
    logic want;
    n = c;
    n.ack = 1'b0;
    if (Rst) begin
      n.booting = 1'b1; n.entering = 1'b0; n.pc = 32'd32; n.valid = 1'b0;
      n.saved = '0; n.isr = 1'b0; n.pend = 1'b0;
    end else if (c.booting) begin
      n.booting = 1'b0; n.valid = 1'b1; n.pend = IntReq;
    end else if (c.entering) begin
      n.entering = 1'b0; n.valid = 1'b1; n.isr = 1'b1; n.pend = c.pend | IntReq;
    end else begin
      want = (c.pend | IntReq) & !c.isr & !Stall;
      n.pend = c.pend | IntReq;
      if (JumpEn) n.pc = jt[i] & mask[i];
      else if (RetEn) begin
        n.pc = raddr & mask[i];
        if (IsRti) n.isr = 1'b0;
      end else if (want) begin
        n.saved = c.pc; n.pc = 32'd0; n.valid = 1'b0; n.pend = 1'b0;
        n.entering = 1'b1; n.ack = 1'b1;
      end else if (!Stall) n.pc = (c.pc + incr[i]) & mask[i];
    end
    return n;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] a_pc[3], a_saved[3];
  assign a_pc[0] = pc0;           assign a_saved[0] = saved0;
  assign a_pc[1] = {24'b0, pc1};  assign a_saved[1] = {24'b0, saved1};
  assign a_pc[2] = {24'b0, pc2};  assign a_saved[2] = {24'b0, saved2};

  // Compare process: every instance against the model on every falling edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("pc[%0d]", i), a_pc[i], m[i].pc);
        chk($sformatf("valid[%0d]", i), 32'(valid[i]), 32'(m[i].valid));
        chk($sformatf("ack[%0d]", i), 32'(ack[i]), 32'(m[i].ack));
        chk($sformatf("saved[%0d]", i), a_saved[i], m[i].saved);
        chk($sformatf("isr[%0d]", i), 32'(isr[i]), 32'(m[i].isr));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge Clk);
    for (int i = 0; i < 3; i++) m[i] = step(m[i], i);
    #1;
  endtask

  task automatic set_jump(input logic [31:0] a0, input logic [7:0] a1, input logic [7:0] a2);
    jaddr0 = a0; jaddr1 = a1; jaddr2 = a2;
    jt[0] = a0; jt[1] = {24'b0, a1}; jt[2] = {24'b0, a2};
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    mask[0] = 32'hFFFF_FFFF; mask[1] = 32'hFF; mask[2] = 32'hFF;
    incr[0] = 1; incr[1] = 1; incr[2] = 4;
    set_jump(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      m[i].booting = 1'b1; m[i].entering = 1'b0; m[i].pc = 0; m[i].valid = 1'b0;
      m[i].ack = 1'b0; m[i].saved = 0; m[i].isr = 1'b0; m[i].pend = 1'b0;
    end

    // Reset for two cycles, then boot and sequential fetch.
    Rst = 1'b1;
    cyc(); cyc();
    chk_en = 1'b1;
    chk("rst_pc", pc0, 32'd32);
    chk("rst_valid", 32'(valid[0]), 32'd0);
    chk("rst_saved", saved0, 32'd0);
    Rst = 1'b0;
    cyc();
    chk("boot_pc", pc0, 32'd32);
    chk("boot_valid", 32'(valid[0]), 32'd1);
    cyc(); cyc(); cyc();
    chk("seq_pc35", pc0, 32'd35);
    chk("seq_pc8_inc4", 32'(pc2), 32'd44);
    repeat (5) cyc();
    chk("seq_pc40", pc0, 32'd40);

    // Jump and interrupt pulse together: jump first, entry next cycle.
    JumpEn = 1'b1; set_jump(32'h100, 8'h00, 8'h00); IntReq = 1'b1;
    cyc();
    JumpEn = 1'b0; IntReq = 1'b0;
    chk("jump_pc", pc0, 32'h100);
    cyc();
    chk("entry_pc", pc0, 32'd0);
    chk("entry_ack", 32'(ack[0]), 32'd1);
    chk("entry_saved", saved0, 32'h100);
    cyc();
    chk("isr_set", 32'(isr[0]), 32'd1);
    chk("isr_ack_low", 32'(ack[0]), 32'd0);
    cyc(); cyc();
    chk("isr_pc2", pc0, 32'd2);

    // Masked request is latched but not taken while in the handler.
    IntReq = 1'b1; cyc();
    IntReq = 1'b0; cyc();
    chk("masked_pc", pc0, 32'd4);
    chk("masked_ack", 32'(ack[0]), 32'd0);
    RetEn = 1'b1; IsRti = 1'b1; raddr = 32'h100;
    cyc();
    RetEn = 1'b0; IsRti = 1'b0;
    chk("rti_pc", pc0, 32'h100);
    chk("rti_isr", 32'(isr[0]), 32'd0);
    cyc();
    chk("reentry_ack", 32'(ack[0]), 32'd1);
    chk("reentry_saved", saved0, 32'h100);
    cyc();

    // Leave handler to 50, then stall three cycles with a pulse in cycle 2.
    RetEn = 1'b1; IsRti = 1'b1; raddr = 32'd50;
    cyc();
    RetEn = 1'b0; IsRti = 1'b0;
    Stall = 1'b1; cyc();
    IntReq = 1'b1; cyc();
    IntReq = 1'b0; cyc();
    chk("stall_pc", pc0, 32'd50);
    Stall = 1'b0; cyc();
    chk("stall_entry_pc", pc0, 32'd0);
    chk("stall_entry_ack", 32'(ack[0]), 32'd1);
    chk("stall_entry_saved", saved0, 32'd50);
    cyc();
    RetEn = 1'b1; IsRti = 1'b1; raddr = 32'h10;
    cyc();
    RetEn = 1'b0; IsRti = 1'b0;

    // Wrap at the top of the address space.
    JumpEn = 1'b1; set_jump(32'hFFFF_FFFF, 8'hFF, 8'hFE);
    cyc();
    JumpEn = 1'b0;
    cyc();
    chk("wrap32", pc0, 32'd0);
    chk("wrap8_inc1", 32'(pc1), 32'h00);
    chk("wrap8_inc4", 32'(pc2), 32'h02);

    // Reset during the entry cycle clears everything including pending.
    IntReq = 1'b1; cyc();
    chk("pre_rst_ack", 32'(ack[0]), 32'd1);
    Rst = 1'b1; cyc();
    chk("mid_rst_pc", pc0, 32'd32);
    chk("mid_rst_ack", 32'(ack[0]), 32'd0);
    chk("mid_rst_isr", 32'(isr[0]), 32'd0);
    chk("mid_rst_valid", 32'(valid[0]), 32'd0);
    chk("mid_rst_saved", saved0, 32'd0);
    Rst = 1'b0; IntReq = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("post_rst_pc", pc0, 32'd35);
    chk("post_rst_ack", 32'(ack[0]), 32'd0);

    @(negedge Clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter unit for the fetch stage. It replaces the single-width PC register with configurable address width, reset/interrupt vectors and increment.
Adds a boot state, a stall hold, a pending-interrupt latch, a one-cycle interrupt-entry state with return-PC capture, and interrupt masking until RTI.
It sits between the fetch-address mux inputs (jump from execute, return address from write-back) and instruction memory.

Parameters:
ADDR_W, 32, width of PC, jump/return addresses and SavedPc
RESET_VEC, 32, PC value loaded on reset
INT_VEC, 0, PC value loaded on interrupt entry
INC, 1, sequential increment per fetch (instruction-memory words)

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst  in  1  synchronous reset, active-high
Stall  in  1  hold sequential fetch and defer interrupt entry
JumpEn  in  1  redirect to JumpAddr
JumpAddr  in  ADDR_W  jump target
RetEn  in  1  redirect to RetAddr (RET/RTI/CALL data from write-back)
IsRti  in  1  qualifies RetEn as RTI, unmasks interrupts
RetAddr  in  ADDR_W  return/call target
IntReq  in  1  interrupt request, level or single-cycle pulse
OutPc  out  ADDR_W  current fetch address (registered)
PcValid  out  1  OutPc is a valid fetch this cycle (registered)
IntAck  out  1  high for exactly the INT_ENTRY cycle
SavedPc  out  ADDR_W  return PC captured at interrupt entry
InIsr  out  1  interrupt handler active, further interrupts masked

Behaviour:
- Reset (Rst=1 at edge, any state): state=BOOT, OutPc=RESET_VEC, PcValid=0, IntAck=0, SavedPc=0, InIsr=0, pending=0. Rst overrides all other inputs.
- States: BOOT, RUN, INT_ENTRY.
- BOOT, one cycle: -> RUN. PcValid<=1. OutPc holds RESET_VEC. pending<=IntReq. Jump, Ret and Stall are ignored.
- RUN: let take_int = (pending|IntReq) & !InIsr & !Stall. First match wins:
  1. JumpEn: OutPc<=JumpAddr.
  2. RetEn: OutPc<=RetAddr. If IsRti, InIsr<=0.
  3. take_int: SavedPc<=OutPc, OutPc<=INT_VEC, PcValid<=0, pending<=0, state->INT_ENTRY.
  4. Stall: OutPc holds.
  5. Otherwise: OutPc<=OutPc+INC, modulo 2^ADDR_W (wraps silently, no flag).
- Pending latch: in any non-reset cycle where IntReq=1 and the interrupt is not taken (masked, stalled, or pre-empted by jump/ret), pending<=1. pending clears only on entry or reset.
- Jump/ret pre-empting an interrupt: the interrupt is entered on the next eligible cycle, so SavedPc = redirect target.
- INT_ENTRY, one cycle: IntAck=1, InIsr<=1, PcValid<=1, OutPc holds INT_VEC, -> RUN. JumpEn, RetEn and Stall are ignored. IntReq is latched into pending (masked until RTI).
- RetEn with IsRti=0 leaves InIsr unchanged.
- RTI with pending=1: the interrupt is re-entered on the cycle after OutPc=RetAddr.
- IntAck is the registered decode of state==INT_ENTRY; it is never high for two consecutive cycles.
- Latencies:
  - Redirect to OutPc update: 1 cycle.
  - IntReq (eligible, RUN) to OutPc=INT_VEC: 1 cycle; IntAck in the same cycle OutPc=INT_VEC.

Test Plan:
- Defaults; Rst high 2 cycles then low -> OutPc=32 with PcValid=0 for 1 cycle, then PcValid=1 and OutPc 32,33,34,35.
- At OutPc=40 assert JumpEn, JumpAddr=0x100 and IntReq pulse together -> OutPc=0x100; next cycle OutPc=0, IntAck=1, SavedPc=0x100; then InIsr=1 and OutPc 1,2.
- With InIsr=1 pulse IntReq -> no entry, OutPc keeps incrementing. Then RetEn+IsRti, RetAddr=0x100 -> OutPc=0x100, InIsr=0. Next cycle entry again with SavedPc=0x100.
- At OutPc=50 hold Stall 3 cycles with an IntReq pulse in cycle 2 -> OutPc stays 50. First unstalled cycle gives OutPc=0, IntAck=1, SavedPc=50.
- ADDR_W=8, INC=1: jump to 0xFF -> next OutPc=0x00. INC=4: jump to 0xFE -> next 0x02.
- Assert Rst during the INT_ENTRY cycle with pending set -> next cycle OutPc=RESET_VEC, IntAck=0, InIsr=0, PcValid=0, SavedPc=0. No interrupt is taken after BOOT unless IntReq is reasserted.
